ez8_prog_loader: RTL

Loads an EZ8 program image into CPU instruction memory from an 8-bit byte stream, such as a UART receiver.
- Parses a framed image and assembles 16-bit instruction words.
- Drives the CPU instruction-write port.
- Holds the CPU in reset and pause for the whole load, then releases it.
- Sits between the byte source and ez8_cpu (instr_writeaddr/instr_writedata/instr_write_en, reset, pause) at the top level.

---
 rtl/ez8_prog_loader_pkg.sv | 21 ++
 rtl/ez8_prog_loader_if.sv | 23 ++
 rtl/ez8_prog_loader.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/ez8_prog_loader_pkg.sv
// Shared types and constants for the EZ8 program loader.
// Holds the loader state enum and the default frame start marker.
package ez8_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CNT_HI,
    CNT_LO,
    DATA_HI,
    DATA_LO,
    WRITE,
    CHECK,
    RELEASE
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  // Word count is 12 bits: {CNT_HI[3:0], CNT_LO}.
  localparam int CNT_W = 12;

endpackage

// File: rtl/ez8_prog_loader_if.sv
// Byte-stream input and instruction-write output of the EZ8 program loader.
// master = byte source / memory side, slave = loader.
interface ez8_prog_loader_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 16
);
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic [ADDR_WIDTH-1:0] instr_writeaddr;
  logic [DATA_WIDTH-1:0] instr_writedata;
  logic                  instr_write_en;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, instr_writeaddr, instr_writedata, instr_write_en
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, instr_writeaddr, instr_writedata, instr_write_en
  );
endinterface

// File: rtl/ez8_prog_loader.sv
// Parses a framed EZ8 image from a byte stream and writes it into instruction memory,
// holding the CPU in reset/pause meanwhile. Optional trailing checksum: LOADER_CHECKSUM_EN.
module ez8_prog_loader
  import ez8_loader_pkg::*;
#(
  parameter int         ADDR_WIDTH = 12,
  parameter int         DATA_WIDTH = 16,
  parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEFAULT
) (
  input  logic                clk,
  input  logic                reset_n,
  ez8_prog_loader_if.slave    bus,
  output logic                cpu_reset,
  output logic                cpu_pause,
  output logic                busy,
  output logic                done,
  output logic                error
);

`ifdef LOADER_CHECKSUM_EN
  localparam state_t LAST_STATE = CHECK;
`else
  localparam state_t LAST_STATE = RELEASE;
`endif

  state_t                r_state;
  state_t                w_next;
  logic                  w_ready;
  logic                  w_accept;
  logic                  w_chk_fail;

  logic [3:0]            r_cnt_hi;
  logic [CNT_W-1:0]      r_remaining;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_hi;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic                  r_cpu_reset;
  logic                  r_cpu_pause;
  logic                  r_busy;
  logic                  r_done;

  assign w_ready  = (r_state != WRITE) && (r_state != RELEASE);
  assign w_accept = bus.rx_valid && w_ready;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] r_sum;
  logic       r_error;

  assign w_chk_fail = (r_state == CHECK) && w_accept && (bus.rx_data != r_sum);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sum   <= '0;
      r_error <= 1'b0;
    end else begin
      if (r_state == IDLE && w_accept && bus.rx_data == SYNC_BYTE) r_error <= 1'b0;
      if (w_chk_fail) r_error <= 1'b1;
      if (r_state == CNT_LO && w_accept) r_sum <= '0;
      if ((r_state == DATA_HI || r_state == DATA_LO) && w_accept)
        r_sum <= r_sum + bus.rx_data;
    end
  end

  assign error = r_error;
`else
  assign w_chk_fail = 1'b0;
  assign error      = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // NOTE: w_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept && bus.rx_data == SYNC_BYTE) w_next = CNT_HI;
      CNT_HI:  if (w_accept) w_next = CNT_LO;
      CNT_LO:  if (w_accept) w_next = ({r_cnt_hi, bus.rx_data} == '0) ? LAST_STATE : DATA_HI;
      DATA_HI: if (w_accept) w_next = DATA_LO;
      DATA_LO: if (w_accept) w_next = WRITE;
      WRITE:   w_next = (r_remaining == CNT_W'(1)) ? LAST_STATE : DATA_HI;
      CHECK: begin
`ifdef LOADER_CHECKSUM_EN
        if (w_accept) w_next = w_chk_fail ? IDLE : RELEASE;
`else
        w_next = IDLE;
`endif
      end
      RELEASE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt_hi    <= '0;
      r_remaining <= '0;
      r_addr      <= '0;
      r_hi        <= '0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_cpu_reset <= 1'b0;
      r_cpu_pause <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_accept && bus.rx_data == SYNC_BYTE) begin
          r_busy      <= 1'b1;
          r_cpu_reset <= 1'b1;
          r_cpu_pause <= 1'b1;
          r_done      <= 1'b0;
        end
        CNT_HI: if (w_accept) r_cnt_hi <= bus.rx_data[3:0];
        CNT_LO: if (w_accept) begin
          r_remaining <= {r_cnt_hi, bus.rx_data};
          r_addr      <= '0;
        end
        DATA_HI: if (w_accept) r_hi <= bus.rx_data;
        // Write port registers load here so they hold steady outside the strobe.
        DATA_LO: if (w_accept) begin
          r_wr_data <= {r_hi, bus.rx_data};
          r_wr_addr <= r_addr;
        end
        WRITE: begin
          r_addr      <= r_addr + ADDR_WIDTH'(1);
          r_remaining <= r_remaining - CNT_W'(1);
        end
        CHECK: if (w_chk_fail) r_busy <= 1'b0;
        RELEASE: begin
          r_cpu_reset <= 1'b0;
          r_cpu_pause <= 1'b0;
          r_busy      <= 1'b0;
          r_done      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.rx_ready        = w_ready;
  assign bus.instr_write_en  = (r_state == WRITE);
  assign bus.instr_writeaddr = r_wr_addr;
  assign bus.instr_writedata = r_wr_data;
  assign cpu_reset           = r_cpu_reset;
  assign cpu_pause           = r_cpu_pause;
  assign busy                = r_busy;
  assign done                = r_done;

endmodule
